fifo_unpacker: RTL and testbench

Read-side drain engine for the team's parameterised FIFO. Pops `PAR_READ`-word groups whenever the FIFO is non-empty, holds each group in a local register and emits it one `WIDTH`-bit word at a time on a valid/ready stream toward the downstream consumer. It sits directly on the FIFO's `read_en`/`dout`/`empty` port, so the consumer never handles the FIFO's pop latency or group width.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_unpacker_if.sv | 33 +++
 rtl/fifo_unpack_shreg.sv | 43 ++++
 rtl/fifo_unpacker.sv | 97 +++++++++
 tb/tb_fifo_unpacker.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared types and defaults for the FIFO and its read-side drain.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH    = 32;
  localparam int unsigned DEFAULT_PAR_READ = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } unpack_state_e;

  // An index must be at least one bit wide even for single-word groups.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_unpacker_if.sv
// ============================================================================
// Module   : fifo_unpacker_if
// Purpose  : FIFO read port plus valid/ready word stream of the unpacker.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface fifo_unpacker_if #(
  parameter int WIDTH    = 32,
  parameter int PAR_READ = 1
);

  logic                      fifo_empty;
  logic                      fifo_read_en;
  logic [PAR_READ*WIDTH-1:0] fifo_dout;
  logic                      m_valid;
  logic                      m_ready;
  logic [WIDTH-1:0]          m_data;
  logic                      m_last;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_read_en, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_read_en, m_valid, m_data, m_last
  );

endinterface

`default_nettype wire

// File: rtl/fifo_unpack_shreg.sv
// ============================================================================
// Module   : fifo_unpack_shreg
// Purpose  : Holding register for one popped group with a word-select mux.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_unpack_shreg #(
  parameter int WIDTH    = 32,
  parameter int PAR_READ = 1,
  parameter int IDX_W    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_i,
  input  logic [PAR_READ*WIDTH-1:0] din_i,
  input  logic [IDX_W-1:0]          idx_i,
  output logic [WIDTH-1:0]          data_o
);

  logic [PAR_READ*WIDTH-1:0] hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else if (load_i) begin
      hold_q <= din_i;
    end
  end

  // Slice 0 sits in the least-significant bits.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < PAR_READ; i++) begin
      if (idx_i == IDX_W'(i)) begin
        data_o = hold_q[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_unpacker.sv
// ============================================================================
// Module   : fifo_unpacker
// Purpose  : Pops PAR_READ-word FIFO groups and streams them word by word.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_unpacker
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PAR_READ = DEFAULT_PAR_READ,
  parameter int IDX_W    = idx_width(PAR_READ)
) (
  input  logic                   clk,
  input  logic                   rst,
  fifo_unpacker_if.master        bus,
  output logic                   busy
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_FETCH = ST_FETCH;
  localparam logic [1:0] S_HOLD  = ST_HOLD;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             w_pop;
  logic             w_last;
  logic             w_hs;

  assign w_last = (state_q == S_HOLD) && (idx_q == IDX_W'(PAR_READ - 1));
  assign w_hs   = (state_q == S_HOLD) && bus.m_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    w_pop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!bus.fifo_empty) begin
          w_pop   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        idx_d   = '0;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (w_hs) begin
          if (!w_last) begin
            idx_d = idx_q + 1'b1;
          end else if (!bus.fifo_empty) begin
            // Chain the next pop into the final handshake to keep one bubble per group.
            w_pop   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  fifo_unpack_shreg #(
    .WIDTH    (WIDTH),
    .PAR_READ (PAR_READ),
    .IDX_W    (IDX_W)
  ) u_shreg (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_q == S_FETCH),
    .din_i  (bus.fifo_dout),
    .idx_i  (idx_q),
    .data_o (bus.m_data)
  );

  // A pop during reset would drop a word the engine can no longer capture.
  assign bus.fifo_read_en = w_pop && !rst;
  assign bus.m_valid      = (state_q == S_HOLD);
  assign bus.m_last       = w_last;
  assign busy             = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fifo_unpacker.sv
// ============================================================================
// Module   : tb_fifo_unpacker
// Purpose  : Directed self-checking bench for PAR_READ=1 and PAR_READ=4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_unpacker;

  logic clk;
  logic rst;
  logic busy1;
  logic busy4;

  int n_checks;
  int n_errors;

  logic [31:0]  q1[$];
  logic [127:0] q4[$];

  fifo_unpacker_if #(.WIDTH(32), .PAR_READ(1)) if1 ();
  fifo_unpacker_if #(.WIDTH(32), .PAR_READ(4)) if4 ();

  fifo_unpacker #(.WIDTH(32), .PAR_READ(1)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .bus  (if1.master),
    .busy (busy1)
  );

  fifo_unpacker #(.WIDTH(32), .PAR_READ(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .bus  (if4.master),
    .busy (busy4)
  );

  always #5 clk = ~clk;

  // FIFO models: data appears on dout the cycle after an accepted pop.
  always @(posedge clk) begin
    if (if1.fifo_read_en && q1.size() > 0) if1.fifo_dout <= q1.pop_front();
    if (if4.fifo_read_en && q4.size() > 0) if4.fifo_dout <= q4.pop_front();
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if1.fifo_empty = (q1.size() == 0);
    if4.fifo_empty = (q4.size() == 0);
    #1;
  endtask

  task automatic push1(input logic [31:0] d);
    q1.push_back(d);
    if1.fifo_empty = 1'b0;
    #1;
  endtask

  task automatic push4(input logic [127:0] d);
    q4.push_back(d);
    if4.fifo_empty = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    push1(32'hA1A1A1A1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({if1.fifo_read_en, if1.m_valid, if1.m_last, busy1, if1.m_data,
           if4.fifo_read_en, if4.m_valid, if4.m_last, busy4, if4.m_data} !== '0) begin
        n_errors++;
        $display("FAIL reset_cyc%0d: rd=%b v=%b l=%b busy=%b data=%h (dut4 rd=%b v=%b busy=%b) expected all 0",
                 i, if1.fifo_read_en, if1.m_valid, if1.m_last, busy1, if1.m_data,
                 if4.fifo_read_en, if4.m_valid, busy4);
      end
    end
    rst = 1'b0;
    if1.m_ready = 1'b1;
    #1;
    n_checks++;
    if (if1.fifo_read_en !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_pop: rd_en=%b expected 1", if1.fifo_read_en);
    end
  endtask

  task automatic test_single();
    logic [3:0] eo [0:2] = '{4'b0010, 4'b1110, 4'b0000};
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({if1.m_valid, if1.m_last, busy1, if1.fifo_read_en} !== eo[i]) begin
        n_errors++;
        $display("FAIL single_ctl%0d: {v,l,busy,rd}=%b expected %b", i,
                 {if1.m_valid, if1.m_last, busy1, if1.fifo_read_en}, eo[i]);
      end
      if (eo[i][3]) begin
        n_checks++;
        if (if1.m_data !== 32'hA1A1A1A1) begin
          n_errors++;
          $display("FAIL single_data: got %h expected a1a1a1a1", if1.m_data);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  eo [0:6] = '{4'b0010, 4'b1111, 4'b0010, 4'b1111, 4'b0010, 4'b1110, 4'b0000};
    logic [31:0] ed [0:6] = '{32'h0, 32'hB2B2B2B2, 32'h0, 32'hC3C3C3C3, 32'h0, 32'hD4D4D4D4, 32'h0};
    push1(32'hB2B2B2B2);
    push1(32'hC3C3C3C3);
    push1(32'hD4D4D4D4);
    n_checks++;
    if ({if1.m_valid, if1.m_last, busy1, if1.fifo_read_en} !== 4'b0001) begin
      n_errors++;
      $display("FAIL b2b_pop: {v,l,busy,rd}=%b expected 0001",
               {if1.m_valid, if1.m_last, busy1, if1.fifo_read_en});
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++;
      if ({if1.m_valid, if1.m_last, busy1, if1.fifo_read_en} !== eo[i]) begin
        n_errors++;
        $display("FAIL b2b_ctl%0d: {v,l,busy,rd}=%b expected %b", i,
                 {if1.m_valid, if1.m_last, busy1, if1.fifo_read_en}, eo[i]);
      end
      if (eo[i][3]) begin
        n_checks++;
        if (if1.m_data !== ed[i]) begin
          n_errors++;
          $display("FAIL b2b_data%0d: got %h expected %h", i, if1.m_data, ed[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    if1.m_ready = 1'b0;
    push1(32'hE5E5E5E5);
    tick();
    tick();
    push1(32'hF6F6F6F6);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({if1.m_valid, if1.m_last, busy1, if1.fifo_read_en, if1.m_data} !== {4'b1110, 32'hE5E5E5E5}) begin
        n_errors++;
        $display("FAIL bp_hold%0d: {v,l,busy,rd}=%b data=%h expected 1110 e5e5e5e5", i,
                 {if1.m_valid, if1.m_last, busy1, if1.fifo_read_en}, if1.m_data);
      end
      tick();
    end
    if1.m_ready = 1'b1;
    #1;
    n_checks++;
    if ({if1.m_valid, if1.fifo_read_en, if1.m_data} !== {2'b11, 32'hE5E5E5E5}) begin
      n_errors++;
      $display("FAIL bp_accept: v=%b rd=%b data=%h expected 1 1 e5e5e5e5",
               if1.m_valid, if1.fifo_read_en, if1.m_data);
    end
    tick();
    tick();
    n_checks++;
    if ({if1.m_valid, if1.m_data} !== {1'b1, 32'hF6F6F6F6}) begin
      n_errors++;
      $display("FAIL bp_next: v=%b data=%h expected 1 f6f6f6f6", if1.m_valid, if1.m_data);
    end
    tick();
  endtask

  task automatic test_par4();
    logic [3:0]  eo [0:10] = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b1111, 4'b0010,
                               4'b1010, 4'b1010, 4'b1010, 4'b1110, 4'b0000};
    logic [31:0] ed [0:10] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0,
                               32'd5, 32'd6, 32'd7, 32'd8, 32'd0};
    if4.m_ready = 1'b1;
    push4({32'h4, 32'h3, 32'h2, 32'h1});
    push4({32'h8, 32'h7, 32'h6, 32'h5});
    n_checks++;
    if (if4.fifo_read_en !== 1'b1) begin
      n_errors++;
      $display("FAIL p4_pop: rd_en=%b expected 1", if4.fifo_read_en);
    end
    for (int i = 0; i < 11; i++) begin
      tick();
      n_checks++;
      if ({if4.m_valid, if4.m_last, busy4, if4.fifo_read_en} !== eo[i]) begin
        n_errors++;
        $display("FAIL p4_ctl%0d: {v,l,busy,rd}=%b expected %b", i,
                 {if4.m_valid, if4.m_last, busy4, if4.fifo_read_en}, eo[i]);
      end
      if (eo[i][3]) begin
        n_checks++;
        if (if4.m_data !== ed[i]) begin
          n_errors++;
          $display("FAIL p4_data%0d: got %h expected %h", i, if4.m_data, ed[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ed [0:3] = '{32'h21, 32'h22, 32'h23, 32'h24};
    push4({32'h14, 32'h13, 32'h12, 32'h11});
    push4({32'h24, 32'h23, 32'h22, 32'h21});
    tick();
    tick();
    tick();
    n_checks++;
    if ({if4.m_valid, if4.m_data} !== {1'b1, 32'h12}) begin
      n_errors++;
      $display("FAIL rmid_word2: v=%b data=%h expected 1 00000012", if4.m_valid, if4.m_data);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (if4.fifo_read_en !== 1'b0) begin
      n_errors++;
      $display("FAIL rmid_rd_in_rst: rd_en=%b expected 0", if4.fifo_read_en);
    end
    tick();
    n_checks++;
    if ({if4.m_valid, if4.m_last, busy4, if4.fifo_read_en, if4.m_data} !== '0) begin
      n_errors++;
      $display("FAIL rmid_cleared: v=%b l=%b busy=%b rd=%b data=%h expected all 0",
               if4.m_valid, if4.m_last, busy4, if4.fifo_read_en, if4.m_data);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (if4.fifo_read_en !== 1'b1) begin
      n_errors++;
      $display("FAIL rmid_repop: rd_en=%b expected 1", if4.fifo_read_en);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({if4.m_valid, if4.m_last, if4.m_data} !== {1'b1, (i == 3), ed[i]}) begin
        n_errors++;
        $display("FAIL rmid_word%0d: v=%b l=%b data=%h expected 1 %b %h", i,
                 if4.m_valid, if4.m_last, if4.m_data, (i == 3), ed[i]);
      end
    end
    tick();
    n_checks++;
    if ({if4.m_valid, busy4} !== 2'b00) begin
      n_errors++;
      $display("FAIL rmid_idle: v=%b busy=%b expected 0 0", if4.m_valid, busy4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    clk            = 1'b0;
    rst            = 1'b1;
    if1.fifo_empty = 1'b1;
    if4.fifo_empty = 1'b1;
    if1.m_ready    = 1'b0;
    if4.m_ready    = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_par4();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
